rs_alu_unit: RTL

Parametrised reservation-station bank plus pipelined ADD/SUB execution unit for the out-of-order core. It accepts dispatched register-register ops with either operand values or producer tags. It snoops the common data bus (CDB) to resolve pending tags and issues ready entries into a LATENCY-stage pipeline. Results are presented to the CDB arbiter through a valid/ready handshake. It generalises the fixed add/sub stations to configurable depth, width, tag range and latency, and adds backpressure and per-entry age-independent lowest-index issue.

---
 rtl/rs_alu_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rs_alu_unit.sv
// rs_alu_unit: reservation-station bank feeding a LATENCY-stage ADD/SUB pipe with CDB snoop.
// Build option RS_CDB_BYPASS_EN: a dispatch captures a same-cycle CDB broadcast instead of stalling.
module rs_alu_unit #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 4,
    parameter int DEPTH    = 4,
    parameter int LATENCY  = 2,
    parameter int TAG_BASE = 1
) (
    input  logic                       CLOCK_50,
    input  logic                       RST,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic                       disp_op,
    input  logic [TAG_W-1:0]           disp_tag1,
    input  logic [TAG_W-1:0]           disp_tag2,
    input  logic [XLEN-1:0]            disp_val1,
    input  logic [XLEN-1:0]            disp_val2,
    output logic [TAG_W-1:0]           disp_tag_out,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [XLEN-1:0]            cdb_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TAG_W-1:0]           res_tag,
    output logic [XLEN-1:0]            res_data,
    output logic [$clog2(DEPTH+1)-1:0] busy_cnt
);
    // state  | meaning
    // FREE   | slot available for dispatch
    // WAIT   | dispatched, operands may still be pending on CDB tags
    // ISSUED | in the execute pipe or holding the result output
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_ISSUED} ent_state_e;

    ent_state_e       st_q   [DEPTH];
    logic             op_q   [DEPTH];
    logic [TAG_W-1:0] tag1_q [DEPTH];
    logic [TAG_W-1:0] tag2_q [DEPTH];
    logic [XLEN-1:0]  val1_q [DEPTH];
    logic [XLEN-1:0]  val2_q [DEPTH];

    logic             s0_op_q;
    logic [XLEN-1:0]  s0_a_q;
    logic [XLEN-1:0]  s0_b_q;
    logic [LATENCY:0] pv_q;
    logic [TAG_W-1:0] ptag_q [LATENCY+1];
    logic [XLEN-1:0]  pres_q [1:LATENCY];
    logic [CW-1:0]    cnt_q;

    logic             cdb_hit;
    logic             any_free;
    logic             any_elig;
    logic             disp_block;
    logic             disp_fire;
    logic             issue_fire;
    logic             free_fire;
    logic             stall;
    logic [IW-1:0]    free_idx;
    logic [IW-1:0]    iss_idx;
    logic [TAG_W-1:0] d_tag1;
    logic [TAG_W-1:0] d_tag2;
    logic [XLEN-1:0]  d_val1;
    logic [XLEN-1:0]  d_val2;

    assign cdb_hit = cdb_valid && (cdb_tag != '0);

    // Descending scan so the lowest matching index wins.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        any_elig = 1'b0;
        iss_idx  = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (st_q[i] == ST_FREE) begin
                any_free = 1'b1;
                free_idx = IW'(i);
            end
            if (st_q[i] == ST_WAIT && tag1_q[i] == '0 && tag2_q[i] == '0) begin
                any_elig = 1'b1;
                iss_idx  = IW'(i);
            end
        end
    end

    always_comb begin
        d_tag1 = disp_tag1;
        d_tag2 = disp_tag2;
        d_val1 = disp_val1;
        d_val2 = disp_val2;
`ifdef RS_CDB_BYPASS_EN
        if (cdb_hit && disp_tag1 == cdb_tag) begin
            d_tag1 = '0;
            d_val1 = cdb_data;
        end
        if (cdb_hit && disp_tag2 == cdb_tag) begin
            d_tag2 = '0;
            d_val2 = cdb_data;
        end
`endif
    end

`ifdef RS_CDB_BYPASS_EN
    assign disp_block = 1'b0;
`else
    assign disp_block = cdb_hit && (disp_tag1 == cdb_tag || disp_tag2 == cdb_tag);
`endif

    assign stall        = pv_q[LATENCY] && !res_ready;
    assign free_fire    = pv_q[LATENCY] && res_ready;
    assign issue_fire   = any_elig && !stall;
    assign disp_ready   = any_free && !disp_block;
    assign disp_fire    = disp_valid && disp_ready;
    assign disp_tag_out = TAG_W'(TAG_BASE) + TAG_W'(free_idx);

    assign res_valid = pv_q[LATENCY];
    assign res_tag   = ptag_q[LATENCY];
    assign res_data  = pres_q[LATENCY];
    assign busy_cnt  = cnt_q;

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]   <= ST_FREE;
                op_q[i]   <= 1'b0;
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
            end
            s0_op_q <= 1'b0;
            s0_a_q  <= '0;
            s0_b_q  <= '0;
            pv_q    <= '0;
            for (int k = 0; k <= LATENCY; k++) ptag_q[k] <= '0;
            for (int k = 1; k <= LATENCY; k++) pres_q[k] <= '0;
            cnt_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (st_q[i] == ST_WAIT && cdb_hit) begin
                    if (tag1_q[i] == cdb_tag) begin
                        tag1_q[i] <= '0;
                        val1_q[i] <= cdb_data;
                    end
                    if (tag2_q[i] == cdb_tag) begin
                        tag2_q[i] <= '0;
                        val2_q[i] <= cdb_data;
                    end
                end
                if (issue_fire && iss_idx == IW'(i))
                    st_q[i] <= ST_ISSUED;
                if (free_fire && ptag_q[LATENCY] == TAG_W'(TAG_BASE + i))
                    st_q[i] <= ST_FREE;
                if (disp_fire && free_idx == IW'(i)) begin
                    st_q[i]   <= ST_WAIT;
                    op_q[i]   <= disp_op;
                    tag1_q[i] <= d_tag1;
                    tag2_q[i] <= d_tag2;
                    val1_q[i] <= d_val1;
                    val2_q[i] <= d_val2;
                end
            end

            // Whole pipe advances in lockstep; idle slots carry zeros so outputs read 0 when invalid.
            if (!stall) begin
                pv_q      <= {pv_q[LATENCY-1:0], issue_fire};
                s0_op_q   <= issue_fire ? op_q[iss_idx]   : 1'b0;
                s0_a_q    <= issue_fire ? val1_q[iss_idx] : '0;
                s0_b_q    <= issue_fire ? val2_q[iss_idx] : '0;
                ptag_q[0] <= issue_fire ? TAG_W'(TAG_BASE) + TAG_W'(iss_idx) : '0;
                ptag_q[1] <= ptag_q[0];
                pres_q[1] <= s0_op_q ? (s0_a_q - s0_b_q) : (s0_a_q + s0_b_q);
                for (int k = 2; k <= LATENCY; k++) begin
                    ptag_q[k] <= ptag_q[k-1];
                    pres_q[k] <= pres_q[k-1];
                end
            end

            cnt_q <= cnt_q + CW'(disp_fire) - CW'(free_fire);
        end
    end
endmodule
